// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage control; issues multi-cycle loads/stores, stalls until done, and writes MEM/WB.
//   Parameter TIMEOUT (2..255): cycles an access may wait for mem_done before it is aborted.
//   Inputs : clk, rst, EX/MEM fields (data_out_i, data_two_i, dst_i, Reg_write_i, Mem_read_i,
//            Mem_write_i, Mem_en_i, Mem_reg_i, Excp_i), memory response (mem_rdata, mem_done).
//   Outputs: memory request (mem_rd, mem_wr, mem_addr, mem_wdata), stall_o, and the MEM/WB
//            register (wb_valid_o, wb_data_o, wb_dst_o, wb_regwrite_o, wb_excp_o).
module mem_stage_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_out_i,
    input  logic [15:0] data_two_i,
    input  logic [2:0]  dst_i,
    input  logic        Reg_write_i,
    input  logic        Mem_read_i,
    input  logic        Mem_write_i,
    input  logic        Mem_en_i,
    input  logic        Mem_reg_i,
    input  logic        Excp_i,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [15:0] wb_data_o,
    output logic [2:0]  wb_dst_o,
    output logic        wb_regwrite_o,
    output logic        wb_excp_o
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t     state;
    logic [7:0] cnt;
    logic       access, bad, go, timeout, excp;
    assign access    = Mem_en_i & (Mem_read_i | Mem_write_i);
    assign bad       = access & (data_out_i[0] | (Mem_read_i & Mem_write_i));
    assign go        = access & ~bad;
    // cnt holds the number of cycles already spent waiting, so the abort lands on wait cycle TIMEOUT
    assign timeout   = (state == WAIT) & go & ~mem_done & (cnt == 8'(TIMEOUT - 1));
    assign stall_o   = go & ~mem_done & ~timeout;
    assign excp      = Excp_i | bad | timeout;
    assign mem_rd    = go & Mem_read_i & ~rst;
    assign mem_wr    = go & Mem_write_i & ~rst;
    assign mem_addr  = data_out_i;
    assign mem_wdata = data_two_i;
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            wb_valid_o    <= 1'b0;
            wb_data_o     <= '0;
            wb_dst_o      <= '0;
            wb_regwrite_o <= 1'b0;
            wb_excp_o     <= 1'b0;
        end else begin
            state         <= stall_o ? WAIT : IDLE;
            cnt           <= stall_o ? cnt + 8'd1 : 8'd0;
            wb_valid_o    <= ~stall_o;
            wb_data_o     <= stall_o ? 16'd0 : ((Mem_reg_i & Mem_read_i) ? mem_rdata : data_out_i);
            wb_dst_o      <= stall_o ? 3'd0 : dst_i;
            wb_regwrite_o <= ~stall_o & Reg_write_i & ~excp;
            wb_excp_o     <= ~stall_o & excp;
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized scoreboard bench for mem_stage_ctrl against a per-instruction latency model.
module tb_mem_stage_ctrl;
    localparam int T = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_out_i = '0, data_two_i = '0, mem_rdata = '0;
    logic [2:0]  dst_i = '0;
    logic        Reg_write_i = 0, Mem_read_i = 0, Mem_write_i = 0, Mem_en_i = 0, Mem_reg_i = 0, Excp_i = 0;
    logic        mem_done = 0;
    logic        mem_rd, mem_wr, stall_o, wb_valid_o, wb_regwrite_o, wb_excp_o;
    logic [15:0] mem_addr, mem_wdata, wb_data_o;
    logic [2:0]  wb_dst_o;

    mem_stage_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .data_out_i(data_out_i), .data_two_i(data_two_i), .dst_i(dst_i),
        .Reg_write_i(Reg_write_i), .Mem_read_i(Mem_read_i), .Mem_write_i(Mem_write_i),
        .Mem_en_i(Mem_en_i), .Mem_reg_i(Mem_reg_i), .Excp_i(Excp_i),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_o(stall_o),
        .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_dst_o(wb_dst_o),
        .wb_regwrite_o(wb_regwrite_o), .wb_excp_o(wb_excp_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  dst;
        logic        rw;
        logic        excp;
        int          bub;
    } exp_t;
    exp_t q[$];
    exp_t me;
    int   tests = 0, fails = 0, bub = 0;
    bit   mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Monitor: every MEM/WB slot is either a bubble or the next queued instruction.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_valid_o) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wb_unexpected: got valid output with empty queue");
                end else begin
                    me = q.pop_front();
                    chk("bubbles", 32'(bub), 32'(me.bub));
                    chk("wb_data", 32'(wb_data_o), 32'(me.data));
                    chk("wb_dst", 32'(wb_dst_o), 32'(me.dst));
                    chk("wb_regwrite", 32'(wb_regwrite_o), 32'(me.rw));
                    chk("wb_excp", 32'(wb_excp_o), 32'(me.excp));
                end
                bub = 0;
            end else begin
                bub++;
                chk("bubble_zero", 32'({wb_data_o, wb_dst_o, wb_regwrite_o, wb_excp_o}), 32'd0);
            end
        end
    end

    task automatic idle_inputs();
        {Mem_en_i, Mem_read_i, Mem_write_i, Mem_reg_i, Reg_write_i, Excp_i, mem_done} = '0;
        data_out_i = '0;
        data_two_i = '0;
        dst_i = '0;
    endtask

    initial begin
        bit first = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_wb", 32'({wb_valid_o, wb_data_o, wb_dst_o, wb_regwrite_o, wb_excp_o}), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
        // Reset in the second cycle of a load miss abandons it silently.
        @(posedge clk) #1;
        rst = 0;
        Mem_en_i = 1; Mem_read_i = 1; Mem_reg_i = 1; Reg_write_i = 1; data_out_i = 16'h0010; dst_i = 3'd5;
        @(negedge clk);
        chk("miss_stall", 32'(stall_o), 32'd1);
        chk("miss_rd", 32'(mem_rd), 32'd1);
        @(posedge clk) #1;
        rst = 1;
        @(negedge clk);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_wr", 32'(mem_wr), 32'd0);
        @(posedge clk) #1;
        rst = 0;
        idle_inputs();
        @(negedge clk);
        chk("rst_wb", 32'({wb_valid_o, wb_data_o, wb_dst_o, wb_regwrite_o, wb_excp_o}), 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] addr, wdat, rdat;
            logic [2:0]  dst;
            logic        en, rd, wr, mreg, rw, ex, acc, bd, go, to, e;
            int          d, r, stalls;
            addr = 16'($urandom);
            if ($urandom_range(0, 4) != 0) addr[0] = 1'b0;
            wdat = 16'($urandom);
            dst  = 3'($urandom);
            en   = $urandom_range(0, 3) != 0;
            rd   = 1'($urandom);
            wr   = $urandom_range(0, 3) == 0 ? rd : ~rd;
            mreg = 1'($urandom);
            rw   = 1'($urandom);
            ex   = $urandom_range(0, 9) == 0;
            r    = $urandom_range(0, 7);
            d    = r == 0 ? 0 : r <= 4 ? $urandom_range(1, 5) : r == 5 ? T - 1 : r == 6 ? T - 2 : 255;
            acc  = en & (rd | wr);
            bd   = acc & (addr[0] | (rd & wr));
            go   = acc & ~bd;
            to   = go && d > T - 1;
            stalls = go ? (d < T - 1 ? d : T - 1) : 0;
            for (int k = 0; k <= T; k++) begin
                @(posedge clk) #1;
                data_out_i = addr; data_two_i = wdat; dst_i = dst; Reg_write_i = rw;
                Mem_read_i = rd; Mem_write_i = wr; Mem_en_i = en; Mem_reg_i = mreg; Excp_i = ex;
                mem_done = (k == d);
                rdat = 16'($urandom);
                mem_rdata = rdat;
                @(negedge clk);
                chk("stall", 32'(stall_o), 32'(k < stalls));
                chk("mem_rd", 32'(mem_rd), 32'(go & rd));
                chk("mem_wr", 32'(mem_wr), 32'(go & wr));
                if (go) chk("mem_addr", 32'({mem_addr, mem_wdata}), {addr, wdat});
                if (first) begin
                    #1 mon_en = 1;
                    first = 0;
                end
                if (k >= stalls) begin
                    e = ex | bd | to;
                    q.push_back('{data: (mreg & rd) ? rdat : addr, dst: dst, rw: rw & ~e, excp: e, bub: stalls});
                    break;
                end
            end
        end
        @(posedge clk) #1;
        idle_inputs();
        @(negedge clk);
        #1 mon_en = 0;
        chk("drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
